// File: rtl/cache_miss_initiator_pkg.sv
// Shared definitions for the L1 miss initiator: protocol command codes,
// FSM state encoding and a constant log2 helper.
package cache_miss_initiator_pkg;

  localparam int CMD_W = 3;

  localparam logic [CMD_W-1:0] CACHE_REQUEST_READIN_BLOCK   = 3'd1;
  localparam logic [CMD_W-1:0] CACHE_REQUEST_WRITEOUT_BLOCK = 3'd2;
  localparam logic [CMD_W-1:0] CACHE_SERVICE_READIN_BLOCK   = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_ISSUE_WRITEOUT = 3'd1,
    ST_ISSUE_READIN   = 3'd2,
    ST_WAIT_FILL      = 3'd3,
    ST_DELIVER        = 3'd4
  } state_e;

  function automatic int CLOG2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cache_miss_initiator_sat_counter.sv
// Saturating event counter: increments on inc_i and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock_i,
  input  logic             resetn_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) count_q <= '0;
    else           count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/cache_miss_initiator.sv
// L1-side block-transfer initiator: optional victim WRITEOUT, then READIN,
// then waits for the SERVICE_READIN response and hands the fill to the core.
module cache_miss_initiator
  import cache_miss_initiator_pkg::*;
#(
  parameter int BW_CACHE_COMMAND      = CMD_W,
  parameter int BW_USED_ADDR_WORD     = 24,
  parameter int BW_DATA_EXTERNAL_BUS  = 512,
  parameter int CACHE_WORDS_PER_BLOCK = 16,
  parameter int BW_WORDS_PER_BLOCK    = CLOG2(CACHE_WORDS_PER_BLOCK),
  parameter int BW_STAT               = 32
) (
  input  logic                            clock_i,
  input  logic                            resetn_i,
  input  logic                            miss_req_i,
  input  logic [BW_USED_ADDR_WORD-1:0]    miss_addr_i,
  input  logic                            evict_dirty_i,
  input  logic [BW_USED_ADDR_WORD-1:0]    evict_addr_i,
  input  logic [BW_DATA_EXTERNAL_BUS-1:0] evict_data_i,
  output logic                            miss_ready_o,
  output logic                            fill_valid_o,
  output logic [BW_USED_ADDR_WORD-1:0]    fill_addr_o,
  output logic [BW_DATA_EXTERNAL_BUS-1:0] fill_data_o,
  output logic                            external_write_o,
  output logic [BW_CACHE_COMMAND-1:0]     external_command_o,
  output logic [BW_USED_ADDR_WORD-1:0]    external_addr_o,
  output logic [BW_DATA_EXTERNAL_BUS-1:0] external_data_o,
  input  logic                            external_full_i,
  input  logic                            external_write_i,
  input  logic [BW_CACHE_COMMAND-1:0]     external_command_i,
  input  logic [BW_USED_ADDR_WORD-1:0]    external_addr_i,
  input  logic [BW_DATA_EXTERNAL_BUS-1:0] external_data_i,
  output logic                            external_full_o,
  output logic [BW_STAT-1:0]              stat_miss_o,
  output logic [BW_STAT-1:0]              stat_writeback_o,
  output logic                            error_o
);

  localparam logic [BW_USED_ADDR_WORD-1:0] ALIGN_MASK =
    {BW_USED_ADDR_WORD{1'b1}} << BW_WORDS_PER_BLOCK;

  state_e                            state_q, state_d;
  logic [BW_USED_ADDR_WORD-1:0]      miss_addr_q, miss_addr_d;
  logic [BW_USED_ADDR_WORD-1:0]      evict_addr_q, evict_addr_d;
  logic [BW_DATA_EXTERNAL_BUS-1:0]   evict_data_q, evict_data_d;
  logic                              miss_ready_q, miss_ready_d;
  logic                              fill_valid_q, fill_valid_d;
  logic [BW_USED_ADDR_WORD-1:0]      fill_addr_q, fill_addr_d;
  logic [BW_DATA_EXTERNAL_BUS-1:0]   fill_data_q, fill_data_d;
  logic                              ext_write_q, ext_write_d;
  logic [BW_CACHE_COMMAND-1:0]       ext_cmd_q, ext_cmd_d;
  logic [BW_USED_ADDR_WORD-1:0]      ext_addr_q, ext_addr_d;
  logic [BW_DATA_EXTERNAL_BUS-1:0]   ext_data_q, ext_data_d;
  logic                              ext_full_q, ext_full_d;
  logic                              error_q, error_d;
  logic                              miss_inc, wb_inc;
  logic                              resp_match;

  assign resp_match = (external_command_i == BW_CACHE_COMMAND'(CACHE_SERVICE_READIN_BLOCK))
                   && (external_addr_i == miss_addr_q);

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    evict_addr_d = evict_addr_q;
    evict_data_d = evict_data_q;
    miss_ready_d = miss_ready_q;
    fill_valid_d = 1'b0;
    fill_addr_d  = fill_addr_q;
    fill_data_d  = fill_data_q;
    ext_write_d  = 1'b0;
    ext_cmd_d    = ext_cmd_q;
    ext_addr_d   = ext_addr_q;
    ext_data_d   = ext_data_q;
    error_d      = error_q;
    miss_inc     = 1'b0;
    wb_inc       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (miss_req_i) begin
          miss_addr_d  = miss_addr_i & ALIGN_MASK;
          evict_addr_d = evict_addr_i & ALIGN_MASK;
          evict_data_d = evict_data_i;
          miss_ready_d = 1'b0;
          miss_inc     = 1'b1;
          state_d      = evict_dirty_i ? ST_ISSUE_WRITEOUT : ST_ISSUE_READIN;
        end
      end
      ST_ISSUE_WRITEOUT: begin
        if (!external_full_i) begin
          ext_write_d = 1'b1;
          ext_cmd_d   = BW_CACHE_COMMAND'(CACHE_REQUEST_WRITEOUT_BLOCK);
          ext_addr_d  = evict_addr_q;
          ext_data_d  = evict_data_q;
          wb_inc      = 1'b1;
          state_d     = ST_ISSUE_READIN;
        end
      end
      ST_ISSUE_READIN: begin
        if (!external_full_i) begin
          ext_write_d = 1'b1;
          ext_cmd_d   = BW_CACHE_COMMAND'(CACHE_REQUEST_READIN_BLOCK);
          ext_addr_d  = miss_addr_q;
          ext_data_d  = '0;
          state_d     = ST_WAIT_FILL;
        end
      end
      ST_WAIT_FILL: begin
        if (external_write_i) begin
          if (resp_match) begin
            fill_valid_d = 1'b1;
            fill_addr_d  = miss_addr_q;
            fill_data_d  = external_data_i;
            state_d      = ST_DELIVER;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_DELIVER: begin
        miss_ready_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Responses are only legal while we advertise room for them.
    if (external_write_i && (state_q != ST_WAIT_FILL)) error_d = 1'b1;

    ext_full_d = (state_d != ST_WAIT_FILL);
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= ST_IDLE;
      miss_addr_q  <= '0;
      evict_addr_q <= '0;
      evict_data_q <= '0;
      miss_ready_q <= 1'b1;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
      ext_write_q  <= 1'b0;
      ext_cmd_q    <= '0;
      ext_addr_q   <= '0;
      ext_data_q   <= '0;
      ext_full_q   <= 1'b1;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      evict_addr_q <= evict_addr_d;
      evict_data_q <= evict_data_d;
      miss_ready_q <= miss_ready_d;
      fill_valid_q <= fill_valid_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
      ext_write_q  <= ext_write_d;
      ext_cmd_q    <= ext_cmd_d;
      ext_addr_q   <= ext_addr_d;
      ext_data_q   <= ext_data_d;
      ext_full_q   <= ext_full_d;
      error_q      <= error_d;
    end
  end

  sat_counter #(.WIDTH(BW_STAT)) u_stat_miss (
    .clock_i  (clock_i),
    .resetn_i (resetn_i),
    .inc_i    (miss_inc),
    .count_o  (stat_miss_o)
  );

  sat_counter #(.WIDTH(BW_STAT)) u_stat_writeback (
    .clock_i  (clock_i),
    .resetn_i (resetn_i),
    .inc_i    (wb_inc),
    .count_o  (stat_writeback_o)
  );

  assign miss_ready_o       = miss_ready_q;
  assign fill_valid_o       = fill_valid_q;
  assign fill_addr_o        = fill_addr_q;
  assign fill_data_o        = fill_data_q;
  assign external_write_o   = ext_write_q;
  assign external_command_o = ext_cmd_q;
  assign external_addr_o    = ext_addr_q;
  assign external_data_o    = ext_data_q;
  assign external_full_o    = ext_full_q;
  assign error_o            = error_q;

endmodule

// File: tb/tb_cache_miss_initiator.sv
// Self-checking bench for cache_miss_initiator: directed vector table, a
// transaction-level reference model under random stimulus, and reset corners.
module tb_cache_miss_initiator;
  import cache_miss_initiator_pkg::*;

  localparam int AW = 24;
  localparam int DW = 512;
  localparam int CW = 3;
  localparam int SW = 2;

  logic          clock_i = 1'b0;
  logic          resetn_i = 1'b0;
  logic          miss_req_i = 1'b0;
  logic [AW-1:0] miss_addr_i = '0;
  logic          evict_dirty_i = 1'b0;
  logic [AW-1:0] evict_addr_i = '0;
  logic [DW-1:0] evict_data_i = '0;
  logic          miss_ready_o;
  logic          fill_valid_o;
  logic [AW-1:0] fill_addr_o;
  logic [DW-1:0] fill_data_o;
  logic          external_write_o;
  logic [CW-1:0] external_command_o;
  logic [AW-1:0] external_addr_o;
  logic [DW-1:0] external_data_o;
  logic          external_full_i = 1'b0;
  logic          external_write_i = 1'b0;
  logic [CW-1:0] external_command_i = '0;
  logic [AW-1:0] external_addr_i = '0;
  logic [DW-1:0] external_data_i = '0;
  logic          external_full_o;
  logic [SW-1:0] stat_miss_o;
  logic [SW-1:0] stat_writeback_o;
  logic          error_o;

  always #5 clock_i = ~clock_i;

  cache_miss_initiator #(
    .BW_CACHE_COMMAND(CW), .BW_USED_ADDR_WORD(AW), .BW_DATA_EXTERNAL_BUS(DW),
    .CACHE_WORDS_PER_BLOCK(16), .BW_WORDS_PER_BLOCK(4), .BW_STAT(SW)
  ) dut (
    .clock_i(clock_i), .resetn_i(resetn_i),
    .miss_req_i(miss_req_i), .miss_addr_i(miss_addr_i),
    .evict_dirty_i(evict_dirty_i), .evict_addr_i(evict_addr_i), .evict_data_i(evict_data_i),
    .miss_ready_o(miss_ready_o), .fill_valid_o(fill_valid_o),
    .fill_addr_o(fill_addr_o), .fill_data_o(fill_data_o),
    .external_write_o(external_write_o), .external_command_o(external_command_o),
    .external_addr_o(external_addr_o), .external_data_o(external_data_o),
    .external_full_i(external_full_i), .external_write_i(external_write_i),
    .external_command_i(external_command_i), .external_addr_i(external_addr_i),
    .external_data_i(external_data_i), .external_full_o(external_full_o),
    .stat_miss_o(stat_miss_o), .stat_writeback_o(stat_writeback_o), .error_o(error_o)
  );

  typedef struct {
    logic [CW-1:0] cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct {
    logic [AW-1:0] maddr;
    bit            dirty;
    logic [AW-1:0] vaddr;
    logic [AW-1:0] exp_ra;
    logic [AW-1:0] exp_wa;
    int            full_hold;
    int            n_bad;
    int            gap;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   exp_miss = 0;
  int   exp_wb = 0;
  logic exp_err = 1'b0;
  int   txn = 0;
  req_t req_q[$];
  vec_t vecs[6];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_block();
    logic [DW-1:0] b;
    for (int i = 0; i < DW / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [SW-1:0] sat(input int n);
    return (n >= (1 << SW) - 1) ? {SW{1'b1}} : SW'(n);
  endfunction

  function automatic logic [AW-1:0] block_of(input logic [AW-1:0] a);
    return AW'((int'(a) / 16) * 16);
  endfunction

  // One full miss transaction. The model: each edge after acceptance at which
  // external_full_i was low emits the next pending request, otherwise none.
  task automatic run_miss(input logic [AW-1:0] maddr, input bit dirty,
                          input logic [AW-1:0] vaddr, input logic [DW-1:0] vdata,
                          input logic [AW-1:0] exp_ra, input logic [AW-1:0] exp_wa,
                          input int full_hold, input bit rnd, input int n_bad,
                          input int gap, input logic [DW-1:0] rdata);
    int   budget;
    logic prev_full;
    req_t r;
    budget = 0;
    while (miss_ready_o !== 1'b1 && budget < 50) begin
      tick();
      budget++;
    end
    check("ready_before_req", DW'(miss_ready_o), DW'(1'b1));
    miss_req_i = 1'b1; miss_addr_i = maddr; evict_dirty_i = dirty;
    evict_addr_i = vaddr; evict_data_i = vdata; external_full_i = 1'b0;
    tick();
    exp_miss++;
    check("ready_after_accept", DW'(miss_ready_o), DW'(1'b0));
    if (dirty) begin
      req_q.push_back('{CACHE_REQUEST_WRITEOUT_BLOCK, exp_wa, vdata});
      exp_wb++;
    end
    req_q.push_back('{CACHE_REQUEST_READIN_BLOCK, exp_ra, '0});
    for (int cyc = 1; req_q.size() > 0 && cyc <= 200; cyc++) begin
      prev_full = (cyc <= full_hold) ? 1'b1 : (rnd ? ($urandom_range(0, 2) == 0) : 1'b0);
      external_full_i = prev_full;
      miss_req_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      miss_addr_i = AW'($urandom);
      evict_dirty_i = 1'($urandom_range(0, 1));
      tick();
      if (!prev_full) begin
        r = req_q.pop_front();
        check("req_write", DW'(external_write_o), DW'(1'b1));
        check("req_cmd", DW'(external_command_o), DW'(r.cmd));
        check("req_addr", DW'(external_addr_o), DW'(r.addr));
        check("req_data", external_data_o, r.data);
      end else begin
        check("no_req_while_full", DW'(external_write_o), DW'(1'b0));
      end
    end
    check("requests_drained", DW'(req_q.size()), DW'(0));
    external_full_i = 1'b0;
    check("full_o_in_wait", DW'(external_full_o), DW'(1'b0));
    for (int g = 0; g < gap; g++) begin
      miss_req_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    for (int b = 0; b < n_bad; b++) begin
      external_write_i = 1'b1;
      external_data_i = rand_block();
      if (b % 2 == 0) begin
        external_command_i = CACHE_SERVICE_READIN_BLOCK;
        external_addr_i = exp_ra ^ 24'h000100;
      end else begin
        external_command_i = CACHE_REQUEST_READIN_BLOCK;
        external_addr_i = exp_ra;
      end
      tick();
      external_write_i = 1'b0;
      exp_err = 1'b1;
      check("bad_resp_no_fill", DW'(fill_valid_o), DW'(1'b0));
      check("bad_resp_error", DW'(error_o), DW'(1'b1));
      check("bad_resp_still_wait", DW'(external_full_o), DW'(1'b0));
    end
    external_write_i = 1'b1;
    external_command_i = CACHE_SERVICE_READIN_BLOCK;
    external_addr_i = exp_ra;
    external_data_i = rdata;
    tick();
    external_write_i = 1'b0;
    check("fill_valid", DW'(fill_valid_o), DW'(1'b1));
    check("fill_addr", DW'(fill_addr_o), DW'(exp_ra));
    check("fill_data", fill_data_o, rdata);
    check("full_o_after_resp", DW'(external_full_o), DW'(1'b1));
    check("ready_during_fill", DW'(miss_ready_o), DW'(1'b0));
    miss_req_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    miss_req_i = 1'b0;
    check("fill_pulse_end", DW'(fill_valid_o), DW'(1'b0));
    check("ready_after_fill", DW'(miss_ready_o), DW'(1'b1));
    check("stat_miss", DW'(stat_miss_o), DW'(sat(exp_miss)));
    check("stat_writeback", DW'(stat_writeback_o), DW'(sat(exp_wb)));
    check("error_flag", DW'(error_o), DW'(exp_err));
    $display("txn %0d: miss=%h dirty=%0d bad=%0d stat_miss=%0d stat_wb=%0d err=%0d",
             txn, maddr, dirty, n_bad, stat_miss_o, stat_writeback_o, error_o);
    txn++;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miss_ready"}, DW'(miss_ready_o), DW'(1'b1));
    check({tag, "_full_o"}, DW'(external_full_o), DW'(1'b1));
    check({tag, "_error"}, DW'(error_o), DW'(1'b0));
    check({tag, "_fill_valid"}, DW'(fill_valid_o), DW'(1'b0));
    check({tag, "_fill_addr"}, DW'(fill_addr_o), DW'(0));
    check({tag, "_fill_data"}, fill_data_o, '0);
    check({tag, "_ext_write"}, DW'(external_write_o), DW'(1'b0));
    check({tag, "_ext_cmd"}, DW'(external_command_o), DW'(0));
    check({tag, "_ext_addr"}, DW'(external_addr_o), DW'(0));
    check({tag, "_ext_data"}, external_data_o, '0);
    check({tag, "_stat_miss"}, DW'(stat_miss_o), DW'(0));
    check({tag, "_stat_wb"}, DW'(stat_writeback_o), DW'(0));
  endtask

  initial begin
    logic [AW-1:0] ma, va;
    bit            dty;

    vecs[0] = '{24'h000123, 1'b0, 24'h000000, 24'h000120, 24'h000000, 0, 0, 20};
    vecs[1] = '{24'h000800, 1'b1, 24'h000450, 24'h000800, 24'h000450, 0, 0, 0};
    vecs[2] = '{24'h00ABCF, 1'b1, 24'h12345F, 24'h00ABC0, 24'h123450, 10, 0, 3};
    vecs[3] = '{24'h000800, 1'b0, 24'h000000, 24'h000800, 24'h000000, 0, 1, 2};
    vecs[4] = '{24'hFFFFFF, 1'b1, 24'hFFFFF7, 24'hFFFFF0, 24'hFFFFF0, 0, 0, 0};
    vecs[5] = '{24'h00000F, 1'b0, 24'h000000, 24'h000000, 24'h000000, 0, 0, 1};

    tick();
    tick();
    check_reset_values("reset");
    resetn_i = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_miss(vecs[i].maddr, vecs[i].dirty, vecs[i].vaddr, rand_block(),
               vecs[i].exp_ra, vecs[i].exp_wa, vecs[i].full_hold, 1'b0,
               vecs[i].n_bad, vecs[i].gap,
               (i == 0) ? {64{8'hA5}} : rand_block());
    end

    for (int i = 0; i < 25; i++) begin
      ma  = AW'($urandom);
      va  = AW'($urandom);
      dty = 1'($urandom_range(0, 1));
      run_miss(ma, dty, va, rand_block(), block_of(ma), block_of(va),
               $urandom_range(0, 3), 1'b1, $urandom_range(0, 2),
               $urandom_range(0, 5), rand_block());
    end

    // Reset asserted mid-cycle while waiting for the fill.
    miss_req_i = 1'b1; miss_addr_i = 24'h000ABC; evict_dirty_i = 1'b0;
    tick();
    miss_req_i = 1'b0;
    tick();
    check("midop_in_wait", DW'(external_full_o), DW'(1'b0));
    #2;
    resetn_i = 1'b0;
    #1;
    check_reset_values("async_reset");
    resetn_i = 1'b1;
    tick();
    external_write_i = 1'b1;
    external_command_i = CACHE_SERVICE_READIN_BLOCK;
    external_addr_i = 24'h000AB0;
    external_data_i = rand_block();
    tick();
    external_write_i = 1'b0;
    check("late_resp_error", DW'(error_o), DW'(1'b1));
    check("late_resp_no_fill", DW'(fill_valid_o), DW'(1'b0));
    check("late_resp_full_o", DW'(external_full_o), DW'(1'b1));
    check("late_resp_ready", DW'(miss_ready_o), DW'(1'b1));
    check("late_resp_stat", DW'(stat_miss_o), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_miss_initiator.md
Name: cache_miss_initiator

Overview:
- L1-side initiator for the block-transfer protocol between the first-level cache and the memory controller.
- Accepts one miss at a time from the L1 cache core.
- For a dirty victim, issues a WRITEOUT_BLOCK request first, then a READIN_BLOCK request.
- Waits for the SERVICE_READIN_BLOCK response and delivers the fill block to the cache core.
- Keeps miss and writeback statistics and a sticky protocol-error flag.

Parameters:
- BW_CACHE_COMMAND, 3: width of the protocol command field.
- BW_USED_ADDR_WORD, 24: width of the word address.
- BW_DATA_EXTERNAL_BUS, 512: width of one cache block on the external bus.
- CACHE_WORDS_PER_BLOCK, 16: words per block.
- BW_WORDS_PER_BLOCK, CLOG2(CACHE_WORDS_PER_BLOCK): number of word-offset bits that are zeroed in issued addresses.
- BW_STAT, 32: width of the statistics counters.

Ports:
- clock_i  in  1  single clock.
- resetn_i  in  1  reset; asynchronous, active-low.
- miss_req_i  in  1  miss request; sampled only while miss_ready_o=1.
- miss_addr_i  in  BW_USED_ADDR_WORD  word address of the missing block.
- evict_dirty_i  in  1  victim block is dirty and must be written out.
- evict_addr_i  in  BW_USED_ADDR_WORD  victim word address.
- evict_data_i  in  BW_DATA_EXTERNAL_BUS  victim block data.
- miss_ready_o  out  1  block idle; a new miss may be accepted.
- fill_valid_o  out  1  one-cycle pulse: fill block is valid.
- fill_addr_o  out  BW_USED_ADDR_WORD  block-aligned address of the fill.
- fill_data_o  out  BW_DATA_EXTERNAL_BUS  fill block data.
- external_write_o  out  1  request push to the next level.
- external_command_o  out  BW_CACHE_COMMAND  request command.
- external_addr_o  out  BW_USED_ADDR_WORD  request address.
- external_data_o  out  BW_DATA_EXTERNAL_BUS  request data.
- external_full_i  in  1  next-level request buffer is full.
- external_write_i  in  1  response push from the next level.
- external_command_i  in  BW_CACHE_COMMAND  response command.
- external_addr_i  in  BW_USED_ADDR_WORD  response address.
- external_data_i  in  BW_DATA_EXTERNAL_BUS  response data.
- external_full_o  out  1  this block cannot accept a response.
- stat_miss_o  out  BW_STAT  count of misses accepted.
- stat_writeback_o  out  BW_STAT  count of WRITEOUT requests issued.
- error_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (resetn_i low, asynchronous) takes effect immediately, including mid-transfer.
  - State goes to ST_IDLE; all latched address/data are cleared.
  - Output reset values: miss_ready_o=1, external_full_o=1, error_o=0; all other outputs 0.
- All outputs are registered. external_full_o=0 only in ST_WAIT_FILL.
- Latched addresses are block-aligned: the low BW_WORDS_PER_BLOCK bits are zeroed when latched.
- ST_IDLE:
  - On miss_req_i=1: latch the miss and victim inputs, clear miss_ready_o, increment stat_miss.
  - Go to ST_ISSUE_WRITEOUT if evict_dirty_i=1, else ST_ISSUE_READIN.
- ST_ISSUE_WRITEOUT:
  - When external_full_i=0: next cycle drive external_write_o=1 for exactly one cycle with command=CACHE_REQUEST_WRITEOUT_BLOCK, addr=victim address, data=victim data.
  - Increment stat_writeback; go to ST_ISSUE_READIN.
  - When external_full_i=1: hold state, external_write_o=0.
- ST_ISSUE_READIN:
  - When external_full_i=0: issue one-cycle command=CACHE_REQUEST_READIN_BLOCK, addr=miss address, data=0; go to ST_WAIT_FILL.
- Issued request fields stay stable until the next issue.
- Back-to-back issue is allowed: for a dirty miss, WRITEOUT goes out at cycle 1 and READIN at cycle 2, provided full stays low.
- ST_WAIT_FILL:
  - A response with external_write_i=1, command=CACHE_SERVICE_READIN_BLOCK and addr=latched miss address:
    - capture the data;
    - drive external_full_o=1 the next cycle;
    - go to ST_DELIVER.
  - A response with a wrong command or address is discarded, error_o is set, and the state stays in ST_WAIT_FILL.
  - No timeout.
- ST_DELIVER:
  - Drive fill_valid_o=1 for one cycle with fill_addr_o and fill_data_o.
  - Set miss_ready_o=1 and return to ST_IDLE.
  - A new miss is accepted no earlier than the cycle after the fill pulse.
- External writes outside ST_WAIT_FILL (external_full_o=1) are a protocol violation: dropped, error_o set.
- miss_req_i while busy is ignored; it is not queued.
- Statistics counters saturate at all-ones; they do not wrap.
- error_o clears only on reset.

Decomposition:
- Shared package/header holds:
  - command codes CACHE_REQUEST_READIN_BLOCK, CACHE_REQUEST_WRITEOUT_BLOCK, CACHE_SERVICE_READIN_BLOCK;
  - the CLOG2 macro;
  - state encodings ST_IDLE, ST_ISSUE_WRITEOUT, ST_ISSUE_READIN, ST_WAIT_FILL, ST_DELIVER (3-bit).
- One sub-module, sat_counter (parameterised width, increment enable, async active-low reset), instantiated twice for the statistics.

Test Plan:
1. Clean miss: addr 0x000123, dirty=0, full low -> one READIN at cycle 1 with addr 0x000120; respond after 20 cycles with data pattern 0xA5..; fill_valid_o pulses with addr 0x000120 and matching data; stat_miss=1, stat_writeback=0.
2. Dirty miss: victim 0x000450 with data D, miss 0x000800 -> WRITEOUT(0x000450, D) at cycle 1, then READIN(0x000800) at cycle 2; stat_writeback=1.
3. Back-pressure: hold external_full_i=1 for 10 cycles during ST_ISSUE_WRITEOUT -> no external_write_o pulse; exactly one WRITEOUT appears the cycle after full drops.
4. Bad response: SERVICE_READIN with addr 0x000900 while waiting on 0x000800 -> discarded, error_o=1, no fill; the correct response then completes the fill.
5. Reset mid-op: assert resetn_i low in ST_WAIT_FILL -> all outputs take reset values immediately; a subsequent response is rejected (external_full_o=1) and sets error_o.
6. Busy miss: miss_req_i while not idle -> ignored, stat_miss unchanged; counter saturation checked with BW_STAT=2 after 5 misses -> stat_miss=3.
